// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared types for the issue-side register scoreboard.
//   creg_addr_t  - architectural integer register index (x0..x31)
//   word_t       - integer register data word
//   reg_vec_t    - one bit per architectural register
//   sb_state_t   - scoreboard issue mode (RUN, or DRAIN to quiesce issue)
//   reg_onehot() - one-hot select of a register; x0 maps to no bit
package reg_scoreboard_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned XLEN     = 64;

    typedef logic [4:0]          creg_addr_t;
    typedef logic [XLEN-1:0]     word_t;
    typedef logic [NUM_REGS-1:0] reg_vec_t;

    typedef enum logic {RUN, DRAIN} sb_state_t;

    // x0 is hardwired zero, so it never owns a scoreboard bit.
    function automatic reg_vec_t reg_onehot(creg_addr_t addr);
        reg_vec_t vec;
        vec = '0;
        if (addr != '0) begin
            vec[addr] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode/issue handshake plus writeback-retire bus.
//   issue_valid/use1/rs1/use2/rs2/we/rd - instruction offered by decode
//   issue_ready                         - scoreboard allows issue this cycle
//   wb_valid/wb_rd                      - a register write retires
// master: decode + writeback side. slave: the scoreboard.
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    logic       issue_valid;
    logic       issue_use1;
    creg_addr_t issue_rs1;
    logic       issue_use2;
    creg_addr_t issue_rs2;
    logic       issue_we;
    creg_addr_t issue_rd;
    logic       issue_ready;
    logic       wb_valid;
    creg_addr_t wb_rd;

    modport master (
        output issue_valid, issue_use1, issue_rs1, issue_use2, issue_rs2,
        output issue_we, issue_rd, wb_valid, wb_rd,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, issue_use1, issue_rs1, issue_use2, issue_rs2,
        input  issue_we, issue_rd, wb_valid, wb_rd,
        output issue_ready
    );

endinterface

// File: rtl/reg_scoreboard_hazard.sv
// reg_scoreboard_hazard: combinational RAW/WAW detection against the busy vector.
//   busy_vec  - outstanding-write bit per register (bit 0 is always 0)
//   use1/rs1  - source 1 read enable and index
//   use2/rs2  - source 2 read enable and index
//   we/rd     - destination write enable and index
//   raw/waw   - read-after-write / write-after-write hazard present
module reg_scoreboard_hazard
    import reg_scoreboard_pkg::*;
(
    input  reg_vec_t   busy_vec,
    input  logic       use1,
    input  creg_addr_t rs1,
    input  logic       use2,
    input  creg_addr_t rs2,
    input  logic       we,
    input  creg_addr_t rd,
    output logic       raw,
    output logic       waw
);

    // x0 needs no special case: its busy bit is held at zero by the owner.
    assign raw = (use1 & busy_vec[rs1]) | (use2 & busy_vec[rs2]);
    assign waw = we & busy_vec[rd];

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-side scoreboard for the 32 x 64-bit integer register file.
// Tracks registers with an outstanding write, stalls issue on RAW/WAW hazards or
// when MAX_INFLIGHT writes are outstanding, and offers a drain mode for
// fence/CSR serialization.
//   clk, reset  - clock, synchronous active-high reset
//   flush       - squash all in-flight writes (highest priority)
//   drain_req   - level request to quiesce issue
//   drained     - in DRAIN with no outstanding writes
//   sb          - issue handshake and writeback bus (slave side)
//   busy_vec    - per-register outstanding-write bits
//   inflight    - number of outstanding writes
//   stall_cnt   - saturating count of cycles with issue_valid & !issue_ready
//   wb_err      - sticky: writeback to a non-busy, nonzero register
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              drain_req,
    output logic              drained,
    reg_scoreboard_if.slave   sb,
    output reg_vec_t          busy_vec,
    output logic [CNT_W-1:0]  inflight,
    output logic [31:0]       stall_cnt,
    output logic              wb_err
);

    sb_state_t        state_q, state_d;
    reg_vec_t         busy_q, busy_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [31:0]      stall_q, stall_d;
    logic             err_q, err_d;

    logic     raw, waw;
    logic     run_ok;
    logic     cap_full;
    logic     ready;
    logic     fire;
    logic     set_en, clr_en, wb_bad;
    reg_vec_t set_vec, clr_vec;

    reg_scoreboard_hazard u_hazard (
        .busy_vec (busy_q),
        .use1     (sb.issue_use1),
        .rs1      (sb.issue_rs1),
        .use2     (sb.issue_use2),
        .rs2      (sb.issue_rs2),
        .we       (sb.issue_we),
        .rd       (sb.issue_rd),
        .raw      (raw),
        .waw      (waw)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // flush deliberately has no effect on the mode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:   if (drain_req)  state_d = DRAIN;
            DRAIN: if (!drain_req) state_d = RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        run_ok  = (state_q == RUN);
        drained = (state_q == DRAIN) && (inflight_q == '0);
    end

    // ---------------- Issue decision ----------------
    // Only writes to a real register consume an in-flight slot.
    assign cap_full = (inflight_q == CNT_W'(MAX_INFLIGHT));

    always_comb begin
        ready = !flush && run_ok && !raw && !waw
                && !(sb.issue_we && (sb.issue_rd != '0) && cap_full);
        fire  = sb.issue_valid && ready;
    end

    assign sb.issue_ready = ready;

    // ---------------- Busy bits and in-flight count ----------------
    // Busy is cleared only at the edge ending the writeback cycle: the register
    // file read in that same cycle still sees the old value, so no bypass.
    always_comb begin
        set_en  = fire && sb.issue_we && (sb.issue_rd != '0);
        set_vec = set_en ? reg_onehot(sb.issue_rd) : '0;
        clr_en  = sb.wb_valid && (sb.wb_rd != '0) && busy_q[sb.wb_rd];
        clr_vec = clr_en ? reg_onehot(sb.wb_rd) : '0;
        // Retiring a register nobody owns means writeback lost track (e.g. a
        // squashed instruction was not killed); flag it but leave state alone.
        wb_bad  = sb.wb_valid && (sb.wb_rd != '0) && !busy_q[sb.wb_rd] && !flush;

        if (flush) begin
            busy_d     = '0;
            inflight_d = '0;
        end else begin
            busy_d     = (busy_q | set_vec) & ~clr_vec;
            inflight_d = inflight_q + CNT_W'(set_en) - CNT_W'(clr_en);
        end

        err_d = err_q | wb_bad;

        stall_d = stall_q;
        if (sb.issue_valid && !ready && !flush && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= '0;
            inflight_q <= '0;
            stall_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            stall_q    <= stall_d;
            err_q      <= err_d;
        end
    end

    assign busy_vec  = busy_q;
    assign inflight  = inflight_q;
    assign stall_cnt = stall_q;
    assign wb_err    = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed test-plan sequences plus randomized traffic, all
// checked every cycle against a set-of-busy-registers model of the scoreboard.
module tb_reg_scoreboard;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        drain_req;
    logic        drained;
    logic [31:0] busy_vec;
    logic [3:0]  inflight;
    logic [31:0] stall_cnt;
    logic        wb_err;

    reg_scoreboard_if sbif ();

    reg_scoreboard #(
        .MAX_INFLIGHT (8),
        .CNT_W        (4)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .flush     (flush),
        .drain_req (drain_req),
        .drained   (drained),
        .sb        (sbif.slave),
        .busy_vec  (busy_vec),
        .inflight  (inflight),
        .stall_cnt (stall_cnt),
        .wb_err    (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic seen_ready;

    // Model: the set of registers with an outstanding write, plus mode flags.
    bit          m_busy [32];
    bit          m_drain;
    bit          m_err;
    logic [31:0] m_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [31:0] m_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit m_ready();
        if (flush || m_drain) return 1'b0;
        if (sbif.issue_use1 && m_busy[sbif.issue_rs1]) return 1'b0;
        if (sbif.issue_use2 && m_busy[sbif.issue_rs2]) return 1'b0;
        if (sbif.issue_we && m_busy[sbif.issue_rd]) return 1'b0;
        if (sbif.issue_we && sbif.issue_rd != 0 && m_count() == 8) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_drain = 1'b0;
        m_err   = 1'b0;
        m_stall = '0;
    endtask

    task automatic model_step();
        bit r;
        if (rst) begin
            model_reset();
            return;
        end
        r = m_ready();
        if (sbif.issue_valid && !r && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            if (sbif.wb_valid && sbif.wb_rd != 0) begin
                if (m_busy[sbif.wb_rd]) m_busy[sbif.wb_rd] = 1'b0;
                else                    m_err = 1'b1;
            end
            if (sbif.issue_valid && r && sbif.issue_we && sbif.issue_rd != 0)
                m_busy[sbif.issue_rd] = 1'b1;
        end
        m_drain = drain_req;
    endtask

    task automatic check_regs();
        chk("busy_vec", 64'(busy_vec), 64'(m_vec()));
        chk("inflight", 64'(inflight), 64'(m_count()));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("wb_err", 64'(wb_err), 64'(m_err));
        chk("drained", 64'(drained), 64'(m_drain && m_count() == 0));
    endtask

    // Inputs are already driven just after a negedge.
    task automatic tick();
        #1;
        seen_ready = sbif.issue_ready;
        chk("issue_ready", 64'(seen_ready), 64'(m_ready()));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_regs();
    endtask

    task automatic set_idle();
        rst              = 1'b0;
        flush            = 1'b0;
        sbif.issue_valid = 1'b0;
        sbif.issue_use1  = 1'b0;
        sbif.issue_rs1   = '0;
        sbif.issue_use2  = 1'b0;
        sbif.issue_rs2   = '0;
        sbif.issue_we    = 1'b0;
        sbif.issue_rd    = '0;
        sbif.wb_valid    = 1'b0;
        sbif.wb_rd       = '0;
    endtask

    task automatic drv_issue(input bit we, input int rd, input bit u1, input int rs1);
        sbif.issue_valid = 1'b1;
        sbif.issue_we    = we;
        sbif.issue_rd    = 5'(rd);
        sbif.issue_use1  = u1;
        sbif.issue_rs1   = 5'(rs1);
        sbif.issue_use2  = 1'b0;
    endtask

    task automatic drv_wb(input bit v, input int rd);
        sbif.wb_valid = v;
        sbif.wb_rd    = 5'(rd);
    endtask

    initial begin
        int q[$];
        set_idle();
        drain_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        chk("reset_busy", 64'(busy_vec), 64'h0);
        chk("reset_inflight", 64'(inflight), 64'h0);
        chk("reset_stall", 64'(stall_cnt), 64'h0);
        chk("reset_wb_err", 64'(wb_err), 64'h0);
        chk("reset_drained", 64'(drained), 64'h0);

        // RAW stall on x5 and no same-cycle writeback bypass.
        drv_issue(1, 5, 0, 0); tick();
        chk("t1_ready", 64'(seen_ready), 64'h1);
        chk("t1_busy", 64'(busy_vec), 64'h20);
        chk("t1_inflight", 64'(inflight), 64'h1);
        drv_issue(0, 0, 1, 5); tick(); tick();
        chk("t1_raw_ready", 64'(seen_ready), 64'h0);
        chk("t1_stall", 64'(stall_cnt), 64'h2);
        drv_wb(1, 5); tick();
        chk("t1_nobypass", 64'(seen_ready), 64'h0);
        drv_wb(0, 0); tick();
        chk("t1_after_wb", 64'(seen_ready), 64'h1);
        chk("t1_stall_final", 64'(stall_cnt), 64'h3);

        // In-flight cap.
        for (int r = 1; r <= 8; r++) begin
            drv_issue(1, r, 0, 0); tick();
        end
        chk("t2_inflight8", 64'(inflight), 64'h8);
        chk("t2_busy", 64'(busy_vec), 64'h1FE);
        drv_issue(1, 9, 0, 0); tick();
        chk("t2_cap_ready", 64'(seen_ready), 64'h0);
        drv_issue(0, 0, 1, 10); tick();
        chk("t2_nowrite_ready", 64'(seen_ready), 64'h1);
        drv_issue(1, 9, 0, 0); drv_wb(1, 3); tick();
        chk("t2_cap_wb_cycle", 64'(seen_ready), 64'h0);
        drv_wb(0, 0); tick();
        chk("t2_x9_issue", 64'(seen_ready), 64'h1);
        chk("t2_busy2", 64'(busy_vec), 64'h3F6);

        // Same-cycle fire and writeback to different registers.
        set_idle(); drv_wb(1, 7); tick();
        drv_issue(1, 7, 0, 0); drv_wb(1, 2); tick();
        chk("t3_ready", 64'(seen_ready), 64'h1);
        chk("t3_busy", 64'(busy_vec), 64'h3F2);
        chk("t3_inflight", 64'(inflight), 64'h7);

        // Flush with a valid issue, then a late writeback.
        set_idle(); flush = 1'b1; drv_issue(1, 12, 0, 0); tick();
        chk("t4_flush_ready", 64'(seen_ready), 64'h0);
        chk("t4_busy", 64'(busy_vec), 64'h0);
        chk("t4_inflight", 64'(inflight), 64'h0);
        set_idle(); drv_wb(1, 4); tick();
        chk("t4_wb_err", 64'(wb_err), 64'h1);
        set_idle(); tick();
        chk("t4_wb_err_sticky", 64'(wb_err), 64'h1);
        rst = 1'b1; tick();
        set_idle(); tick();
        chk("t4_reset_err", 64'(wb_err), 64'h0);

        // Drain.
        drv_issue(1, 1, 0, 0); tick();
        drv_issue(1, 2, 0, 0); tick();
        set_idle(); drain_req = 1'b1; tick();
        drv_issue(0, 0, 0, 0); tick();
        chk("t5_drain_ready", 64'(seen_ready), 64'h0);
        chk("t5_drained0", 64'(drained), 64'h0);
        set_idle(); drv_wb(1, 1); tick();
        drv_wb(1, 2); tick();
        chk("t5_drained1", 64'(drained), 64'h1);
        set_idle(); drain_req = 1'b0; tick();
        drv_issue(0, 0, 0, 0); tick();
        chk("t5_run_ready", 64'(seen_ready), 64'h1);

        // x0 is never tracked.
        drv_issue(1, 0, 0, 0); tick();
        chk("t6_busy", 64'(busy_vec), 64'h0);
        chk("t6_inflight", 64'(inflight), 64'h0);
        set_idle(); drv_wb(1, 0); tick();
        chk("t6_wb_err", 64'(wb_err), 64'h0);

        // Randomized traffic on a narrow register window to provoke hazards.
        for (int c = 0; c < 3000; c++) begin
            set_idle();
            rst   = ($urandom_range(299) == 0);
            flush = ($urandom_range(39) == 0);
            if ($urandom_range(29) == 0) drain_req = ~drain_req;
            sbif.issue_valid = ($urandom_range(3) != 0);
            sbif.issue_use1  = 1'($urandom_range(1));
            sbif.issue_rs1   = 5'($urandom_range(11));
            sbif.issue_use2  = 1'($urandom_range(1));
            sbif.issue_rs2   = 5'($urandom_range(11));
            sbif.issue_we    = ($urandom_range(2) != 0);
            sbif.issue_rd    = 5'($urandom_range(11));
            sbif.wb_valid    = 1'($urandom_range(1));
            q.delete();
            for (int i = 1; i < 32; i++) if (m_busy[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(7) != 0)
                sbif.wb_rd = 5'(q[$urandom_range(q.size() - 1)]);
            else
                sbif.wb_rd = 5'($urandom_range(11));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Issue-side scoreboard for the 32 x 64-bit integer register file of the in-order pipeline.
- Tracks which architectural registers have an outstanding write and stalls issue on RAW or WAW hazards.
- Bounds the number of in-flight writes and provides a drain mode for fence/CSR serialization.
- Sits between decode and issue; writeback notifies it when each register write retires.

Parameters:
- MAX_INFLIGHT, 8, maximum outstanding register writes; issue stalls when reached.
- CNT_W, 4, width of the in-flight counter; must hold MAX_INFLIGHT.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  squash all in-flight writes; clears scoreboard
- drain_req  input  1  level; request to quiesce issue (fence/CSR)
- drained  output  1  high while in DRAIN and inflight==0
- issue_valid  input  1  decode presents an instruction
- issue_use1  input  1  instruction reads rs1
- issue_rs1  input  5  source register 1 (creg_addr_t)
- issue_use2  input  1  instruction reads rs2
- issue_rs2  input  5  source register 2
- issue_we  input  1  instruction writes rd
- issue_rd  input  5  destination register
- issue_ready  output  1  combinational; instruction may issue this cycle
- wb_valid  input  1  a register write retires this cycle
- wb_rd  input  5  register being written
- busy_vec  output  32  per-register outstanding-write bits; bit 0 always 0
- inflight  output  CNT_W  count of outstanding writes
- stall_cnt  output  32  perf counter: cycles with issue_valid & !issue_ready
- wb_err  output  1  sticky; writeback to a non-busy, nonzero register

Behaviour:
- Reset values: busy_vec=0, inflight=0, stall_cnt=0, wb_err=0, state=RUN, drained=0.
- FSM states: RUN, DRAIN.
  - RUN->DRAIN when drain_req=1.
  - DRAIN->RUN when drain_req=0.
  - flush does not change state.
- Hazard definition; x0 is never busy, and issue to rd=0 never sets a bit:
  - raw = (issue_use1 & busy[rs1]) | (issue_use2 & busy[rs2])
  - waw = issue_we & busy[rd]
- issue_ready = !flush & state==RUN & !raw & !waw & !(issue_we & rd!=0 & inflight==MAX_INFLIGHT).
- issue_ready is independent of issue_valid.
- fire = issue_valid & issue_ready.
  - On fire with issue_we & rd!=0: busy[rd] is set at the next posedge and inflight increments.
- Writeback with wb_valid & wb_rd!=0 & busy[wb_rd]: busy[wb_rd] clears at the next posedge and inflight decrements.
- No same-cycle bypass: a wb in cycle N clears busy at the posedge ending N. An issue in cycle N depending on that register still stalls, because the register-file read does not see the write until N+1.
- Fire and wb to different registers in the same cycle: both take effect and inflight is unchanged.
  - Fire and wb to the same rd cannot coincide, because the WAW check blocks it.
- Writeback to a non-busy, nonzero register, with flush=0:
  - wb_err is set and stays set until reset.
  - busy_vec and inflight are unchanged (no underflow).
  - wb_rd=0 is silently ignored.
- flush has highest priority:
  - busy_vec=0 and inflight=0 at the next posedge.
  - The same-cycle fire and wb are ignored, and issue_ready=0 during flush.
- After a flush, late writebacks of squashed instructions raise wb_err. Writeback must therefore kill squashed instructions before asserting wb_valid.
- drained = (state==DRAIN) & (inflight==0); it is registered-state-derived, i.e. combinational from state and inflight.
- stall_cnt increments when issue_valid & !issue_ready & !flush, saturating at 0xFFFFFFFF.
- Reset mid-operation: all state returns to its reset values on that edge, regardless of other inputs.

Decomposition:
- Use creg_addr_t and word_t from the common package.
- Add to the pipes package: sb_state_t enum {RUN, DRAIN}.
- Optional combinational sub-module sb_hazard_check: takes busy_vec and the issue fields, outputs raw/waw. Keep the rest flat.

Test Plan:
- Reset, then issue add x5 (we, rd=5) -> ready=1; next cycle busy_vec=0x20, inflight=1. Issue use1 rs1=5 -> ready=0, stall_cnt increments each cycle. wb_rd=5 in cycle N -> ready stays 0 in N and becomes 1 in N+1.
- Issue 8 writes to x1..x8 with no writeback -> inflight=8. A 9th write to x9 gets ready=0. A non-writing instruction using x10 gets ready=1. wb x3 -> the x9 write issues next cycle.
- Same cycle: fire a write to x7 and wb of x2 (busy) -> busy_vec toggles both bits, inflight unchanged.
- With x4, x6 busy, assert flush alongside issue_valid -> ready=0, no issue. Next cycle busy_vec=0, inflight=0. A later wb_rd=4 -> wb_err=1 and stays set.
- drain_req=1 with inflight=2 -> ready=0, drained=0. After two wbs, drained=1. Drop drain_req -> RUN, ready=1.
- Issue with rd=0 and we=1 -> busy_vec stays 0, inflight stays 0. wb_rd=0 -> wb_err stays 0.
